// File: rtl/btn_conditioner_if.sv
// Button conditioner signal bundle: raw pin in, debounced level and event strobes out.
// The slave side is the conditioner; the master side drives the pin and consumes events.
interface btn_conditioner_if;
   logic btn_in;
   logic btn_level;
   logic press_pulse;
   logic release_pulse;
   logic long_pulse;
   logic held_long;
   logic repeat_pulse;

   modport master (
      output btn_in,
      input  btn_level, press_pulse, release_pulse, long_pulse, held_long, repeat_pulse
   );

   modport slave (
      input  btn_in,
      output btn_level, press_pulse, release_pulse, long_pulse, held_long, repeat_pulse
   );
endinterface

// File: rtl/btn_conditioner.sv
// Synchronises, debounces and classifies one pushbutton into level, press/release/long events.
// Optional auto-repeat strobes while long-held are built only when AUTO_REPEAT_EN is defined.
//
// state      | meaning
// IDLE       | button released and stable
// PRESS_DB   | qualifying a rising level
// PRESSED    | accepted press, timing towards long press
// LONG_HELD  | long press reached, held_long asserted
// RELEASE_DB | qualifying a falling level, hold timer frozen
module btn_conditioner #(
   parameter int SYNC_STAGES       = 2,
   parameter int DEBOUNCE_CYCLES   = 1000000,
   parameter int LONG_PRESS_CYCLES = 200000000,
   parameter int REPEAT_CYCLES     = 25000000
) (
   input logic              clk_100MHz,
   input logic              reset_n,
   btn_conditioner_if.slave btn
);
   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [DB_W-1:0]   DB_LOAD   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(LONG_PRESS_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

   // Down-counters load N-1 on the first qualifying sample, so the terminal compare sits on sample N.
   generate
      if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 1 || REPEAT_CYCLES < 1)
      begin : g_param_check
         $error("btn_conditioner: parameter out of range");
      end
   endgenerate

   typedef enum logic [2:0] {IDLE, PRESS_DB, PRESSED, LONG_HELD, RELEASE_DB} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   btn_sync;
   logic [DB_W-1:0]        db_tmr;
   logic [HOLD_W-1:0]      hold_tmr;
   logic                   level_q;
   logic                   press_q;
   logic                   release_q;
   logic                   long_q;
   logic                   held_long_q;

   assign btn_sync = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn.btn_in};
      end
   end

`ifdef AUTO_REPEAT_EN
   localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
   localparam logic [REP_W-1:0] REP_LOAD = REP_W'(REPEAT_CYCLES - 1);
   localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
   logic [REP_W-1:0] rep_tmr;
   logic             repeat_q;
   assign btn.repeat_pulse = repeat_q;
`else
   assign btn.repeat_pulse = 1'b0;
`endif

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         db_tmr      <= '0;
         hold_tmr    <= '0;
         level_q     <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         long_q      <= 1'b0;
         held_long_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
         rep_tmr     <= '0;
         repeat_q    <= 1'b0;
`endif
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
`ifdef AUTO_REPEAT_EN
         repeat_q  <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (btn_sync) begin
                  state  <= PRESS_DB;
                  db_tmr <= DB_LOAD;
               end
            end
            PRESS_DB: begin
               if (!btn_sync) begin
                  state <= IDLE;
               end else if (db_tmr == DB_ONE) begin
                  state    <= PRESSED;
                  press_q  <= 1'b1;
                  level_q  <= 1'b1;
                  hold_tmr <= HOLD_LOAD;
               end else begin
                  db_tmr <= db_tmr - DB_ONE;
               end
            end
            PRESSED: begin
               if (!btn_sync) begin
                  state  <= RELEASE_DB;
                  db_tmr <= DB_LOAD;
               end else if (hold_tmr == '0) begin
                  state       <= LONG_HELD;
                  long_q      <= 1'b1;
                  held_long_q <= 1'b1;
`ifdef AUTO_REPEAT_EN
                  rep_tmr     <= REP_LOAD;
`endif
               end else begin
                  hold_tmr <= hold_tmr - HOLD_ONE;
               end
            end
            LONG_HELD: begin
               if (!btn_sync) begin
                  state  <= RELEASE_DB;
                  db_tmr <= DB_LOAD;
               end
`ifdef AUTO_REPEAT_EN
               else if (rep_tmr == '0) begin
                  repeat_q <= 1'b1;
                  rep_tmr  <= REP_LOAD;
               end else begin
                  rep_tmr <= rep_tmr - REP_ONE;
               end
`endif
            end
            RELEASE_DB: begin
               // held_long doubles as the record of which held state the release came from
               if (btn_sync) begin
                  state <= held_long_q ? LONG_HELD : PRESSED;
               end else if (db_tmr == DB_ONE) begin
                  state       <= IDLE;
                  release_q   <= 1'b1;
                  level_q     <= 1'b0;
                  held_long_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
                  rep_tmr     <= '0;
`endif
               end else begin
                  db_tmr <= db_tmr - DB_ONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign btn.btn_level     = level_q;
   assign btn.press_pulse   = press_q;
   assign btn.release_pulse = release_q;
   assign btn.long_pulse    = long_q;
   assign btn.held_long     = held_long_q;
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed and randomised bench for btn_conditioner against a run-length reference model.
module tb_btn_conditioner;
   localparam int SYNC = 2;
   localparam int DB   = 8;
   localparam int LONG = 32;
   localparam int REP  = 16;

   logic clk_100MHz = 1'b0;
   logic reset_n    = 1'b0;
   btn_conditioner_if bif ();

   always #5 clk_100MHz = ~clk_100MHz;

   btn_conditioner #(
      .SYNC_STAGES      (SYNC),
      .DEBOUNCE_CYCLES  (DB),
      .LONG_PRESS_CYCLES(LONG),
      .REPEAT_CYCLES    (REP)
   ) u_dut (
      .clk_100MHz(clk_100MHz),
      .reset_n   (reset_n),
      .btn       (bif.slave)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // reference model: pin delay line, run length of samples disagreeing with the level, held-sample counts
   logic [SYNC-1:0] m_sync;
   logic m_lvl, m_long;
   int   m_run, m_held, m_rep;
   logic e_press, e_release, e_long, e_repeat;

   // event log for directed timing checks
   int n_press, n_release, n_long, n_repeat;
   int c_press, c_release, c_long, c_repeat;

   task automatic model_reset();
      m_sync = '0; m_lvl = 1'b0; m_long = 1'b0;
      m_run = 0; m_held = 0; m_rep = 0;
      e_press = 1'b0; e_release = 1'b0; e_long = 1'b0; e_repeat = 1'b0;
   endtask

   task automatic model_edge();
      logic s;
      int   prev_run;
      s = m_sync[SYNC-1];
      m_sync = {m_sync[SYNC-2:0], bif.btn_in};
      e_press = 1'b0; e_release = 1'b0; e_long = 1'b0; e_repeat = 1'b0;
      prev_run = m_run;
      m_run = (s != m_lvl) ? m_run + 1 : 0;
      if (m_run == DB) begin
         m_lvl = s;
         m_run = 0;
         m_rep = 0;
         if (s) begin
            e_press = 1'b1;
            m_held  = 0;
         end else begin
            e_release = 1'b1;
            m_long    = 1'b0;
         end
      end else if (m_lvl && s && prev_run == 0) begin
         if (!m_long) begin
            m_held++;
            if (m_held == LONG) begin
               e_long = 1'b1;
               m_long = 1'b1;
               m_rep  = 0;
            end
         end else begin
`ifdef AUTO_REPEAT_EN
            m_rep++;
            if (m_rep == REP) begin
               e_repeat = 1'b1;
               m_rep    = 0;
            end
`endif
         end
      end
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b cyc=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d cyc=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_all();
      chk("btn_level",     bif.btn_level,     m_lvl);
      chk("held_long",     bif.held_long,     m_long);
      chk("press_pulse",   bif.press_pulse,   e_press);
      chk("release_pulse", bif.release_pulse, e_release);
      chk("long_pulse",    bif.long_pulse,    e_long);
      chk("repeat_pulse",  bif.repeat_pulse,  e_repeat);
      chk("pulse_excl", ($countones({bif.press_pulse, bif.release_pulse, bif.long_pulse}) <= 1), 1'b1);
   endtask

   task automatic clear_log();
      n_press = 0; n_release = 0; n_long = 0; n_repeat = 0;
      c_press = -1; c_release = -1; c_long = -1; c_repeat = -1;
   endtask

   task automatic step(input logic b);
      bif.btn_in = b;
      @(posedge clk_100MHz);
      cyc++;
      if (reset_n) model_edge();
      else model_reset();
      #1;
      check_all();
      if (bif.press_pulse)   begin n_press++;   c_press   = cyc; end
      if (bif.release_pulse) begin n_release++; c_release = cyc; end
      if (bif.long_pulse)    begin n_long++;    c_long    = cyc; end
      if (bif.repeat_pulse)  begin n_repeat++;  c_repeat  = cyc; end
   endtask

   task automatic steps(input logic b, input int n);
      for (int i = 0; i < n; i++) step(b);
   endtask

   task automatic apply_reset(input logic b, input int n);
      reset_n = 1'b0;
      model_reset();
      #1;
      check_all();
      steps(b, n);
      reset_n = 1'b1;
   endtask

   int t0;
   int t_fall;

   initial begin
      bif.btn_in = 1'b0;
      model_reset();
      clear_log();
      #1;
      check_all();
      steps(1'b0, 3);
      reset_n = 1'b1;
      steps(1'b0, 5);

      // clean press
      clear_log(); t0 = cyc;
      steps(1'b1, 20);
      steps(1'b0, 15);
      chk_int("clean_press_cycle",   c_press,   t0 + 10);
      chk_int("clean_release_cycle", c_release, t0 + 30);
      chk_int("clean_long_count",    n_long,    0);

      // bounce every 3 cycles
      clear_log();
      for (int i = 0; i < 10; i++) steps(i[0] ? 1'b0 : 1'b1, 3);
      steps(1'b0, 15);
      chk_int("bounce_pulses", n_press + n_release + n_long, 0);
      chk("bounce_level", bif.btn_level, 1'b0);

      // long press
      clear_log(); t0 = cyc;
      steps(1'b1, 60);
      chk("long_held_level", bif.held_long, 1'b1);
      steps(1'b0, 15);
      chk_int("long_press_cycle",   c_press,   t0 + 10);
      chk_int("long_long_cycle",    c_long,    t0 + 42);
      chk_int("long_release_cycle", c_release, t0 + 70);
`ifndef AUTO_REPEAT_EN
      chk_int("long_no_repeat", n_repeat, 0);
`endif

      // release bounce: the high gap resumes the hold count but must not emit pulses
      clear_log(); t0 = cyc;
      steps(1'b1, 28);
      steps(1'b0, 5);
      steps(1'b1, 6);
      t_fall = cyc;
      steps(1'b0, 20);
      chk_int("relb_release_count", n_release, 1);
      chk_int("relb_release_cycle", c_release, t_fall + 10);
      chk_int("relb_press_count",   n_press,   1);

      // reset mid-press with the button still held
      clear_log(); t0 = cyc;
      steps(1'b1, 20);
      apply_reset(1'b1, 5);
      clear_log();
      steps(1'b1, 15);
      chk_int("rst_new_press_cycle", c_press, t0 + 35);
      steps(1'b0, 15);

`ifdef AUTO_REPEAT_EN
      clear_log(); t0 = cyc;
      steps(1'b1, 80);
      chk_int("rep_count_held", n_repeat, 2);
      chk_int("rep_last_cycle", c_repeat, t0 + 74);
      steps(1'b0, 20);
      chk_int("rep_none_after_release", n_repeat, 2);
`endif

      // randomised segments with occasional resets
      for (int i = 0; i < 60; i++) begin
         logic lvl;
         int   len;
         if ($urandom_range(0, 14) == 0) apply_reset(1'($urandom_range(0, 1)), $urandom_range(1, 4));
         lvl = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : $urandom_range(10, 70);
         steps(lvl, len);
      end
      steps(1'b0, 20);
      chk("final_level", bif.btn_level, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
